// File: rtl/mgmt_mprj_wb_guard.sv
// mgmt_mprj_wb_guard: registered, timeout-bounded bridge from the management core's mprj Wishbone master to the user project.
// Define MPRJ_WB_STATUS_EN to build the timeout status registers (sticky flag, saturating count, last address).
module mgmt_mprj_wb_guard #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DW-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic          core_clk,
  input  logic          core_rstn,
  input  logic          mprj_cyc_o,
  input  logic          mprj_stb_o,
  input  logic          mprj_we_o,
  input  logic [3:0]    mprj_sel_o,
  input  logic [AW-1:0] mprj_adr_o,
  input  logic [DW-1:0] mprj_dat_o,
  input  logic          mprj_wb_iena,
  output logic          mprj_ack_i,
  output logic [DW-1:0] mprj_dat_i,
  output logic          usr_cyc_o,
  output logic          usr_stb_o,
  output logic          usr_we_o,
  output logic [3:0]    usr_sel_o,
  output logic [AW-1:0] usr_adr_o,
  output logic [DW-1:0] usr_dat_o,
  input  logic          usr_ack_i,
  input  logic [DW-1:0] usr_dat_i,
  input  logic          timeout_clr,
  output logic          timeout_sticky,
  output logic [7:0]    timeout_count,
  output logic [AW-1:0] timeout_adr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic w_req, w_start, w_dis, w_abort, w_ack, w_to;
  assign w_req   = mprj_cyc_o & mprj_stb_o;
  assign w_start = r_state == IDLE && w_req && mprj_wb_iena;
  assign w_dis   = r_state == IDLE && w_req && !mprj_wb_iena;
  assign w_abort = r_state == REQ && !mprj_cyc_o;
  assign w_ack   = r_state == REQ && mprj_cyc_o && usr_ack_i && mprj_wb_iena;
  assign w_to    = r_state == REQ && mprj_cyc_o && !(usr_ack_i && mprj_wb_iena) && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign mprj_ack_i = r_state == RESP;
  always_ff @(posedge core_clk or negedge core_rstn)
    if (!core_rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? REQ : w_dis ? RESP : IDLE;
      REQ:     w_next = w_abort ? IDLE : (w_ack || w_to) ? RESP : REQ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      usr_cyc_o  <= 1'b0;
      usr_stb_o  <= 1'b0;
      usr_we_o   <= 1'b0;
      usr_sel_o  <= '0;
      usr_adr_o  <= '0;
      usr_dat_o  <= '0;
      mprj_dat_i <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_start) begin
        usr_cyc_o <= 1'b1;
        usr_stb_o <= 1'b1;
        usr_we_o  <= mprj_we_o;
        usr_sel_o <= mprj_sel_o;
        usr_adr_o <= mprj_adr_o;
        usr_dat_o <= mprj_dat_o;
        r_cnt     <= '0;
      end
      if (w_abort || w_ack || w_to) begin
        usr_cyc_o <= 1'b0;
        usr_stb_o <= 1'b0;
      end
      if (r_state == REQ && !w_abort && !w_ack && !w_to) r_cnt <= r_cnt + 1'b1;
      if (w_ack) mprj_dat_i <= usr_dat_i;
      if (w_to || w_dis) mprj_dat_i <= TIMEOUT_DATA;
    end
  end
`ifdef MPRJ_WB_STATUS_EN
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      timeout_sticky <= 1'b0;
      timeout_count  <= '0;
      timeout_adr    <= '0;
    end else if (timeout_clr) begin
      timeout_sticky <= 1'b0;
      timeout_count  <= '0;
      timeout_adr    <= '0;
    end else if (w_to) begin
      timeout_sticky <= 1'b1;
      timeout_count  <= timeout_count + {7'd0, timeout_count != 8'hFF};
      timeout_adr    <= usr_adr_o;
    end
  end
`else
  logic w_unused;
  assign w_unused       = timeout_clr;
  assign timeout_sticky = 1'b0;
  assign timeout_count  = '0;
  assign timeout_adr    = '0;
`endif
endmodule
